// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard FIFO peripheral: register offsets,
// STATUS/CTRL bit positions and the decoded register-select type.
package kbd_pkg;

  localparam int unsigned KBD_REG_DATA   = 0;
  localparam int unsigned KBD_REG_STATUS = 1;
  localparam int unsigned KBD_REG_CTRL   = 2;
  localparam int unsigned KBD_REG_COUNT  = 3;

  localparam int unsigned KBD_STAT_EMPTY = 0;
  localparam int unsigned KBD_STAT_FULL  = 1;
  localparam int unsigned KBD_STAT_OVF   = 2;
  localparam int unsigned KBD_STAT_IRQ   = 3;

  localparam int unsigned KBD_CTRL_IRQ_EN  = 0;
  localparam int unsigned KBD_CTRL_FLUSH   = 1;
  localparam int unsigned KBD_CTRL_OVF_CLR = 2;

  typedef enum logic [2:0] {
    SEL_DATA,
    SEL_STATUS,
    SEL_CTRL,
    SEL_COUNT,
    SEL_NONE
  } kbd_sel_e;

endpackage

// File: rtl/kbd_sync_fifo.sv
// Synchronous FIFO for key codes: push/pop/flush with full, empty, fill count
// and combinational head data. Storage is not reset.
module kbd_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W-1:0]        head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted
  assign do_rd = pop & ~empty;
  assign do_wr = push & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_wr && !do_rd)      count <= count + CNT_W'(1);
      else if (!do_wr && do_rd) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/kbd_fifo_periph.sv
// Memory-mapped keyboard peripheral: FIFO-buffered key codes behind
// DATA/STATUS/CTRL/COUNT registers. Define KBD_IRQ_EN to enable the level irq.
module kbd_fifo_periph #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              write,
  input  logic              read,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_code,
  output logic              irq
);

  import kbd_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  kbd_sel_e          sel;
  logic              rd_en;
  logic              wr_en;
  logic              bus_push;
  logic              ctrl_wr;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              flush;
  logic              ovf_clr;
  logic              ovf_set;
  logic              overflow;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head;
  logic              irq_en;
  logic              irq_pend;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    sel = SEL_NONE;
    if (address == ADDR_W'(KBD_REG_DATA))        sel = SEL_DATA;
    else if (address == ADDR_W'(KBD_REG_STATUS)) sel = SEL_STATUS;
    else if (address == ADDR_W'(KBD_REG_CTRL))   sel = SEL_CTRL;
    else if (address == ADDR_W'(KBD_REG_COUNT))  sel = SEL_COUNT;
  end

  assign rd_en    = enable & read;
  assign wr_en    = enable & write;
  assign bus_push = wr_en & (sel == SEL_DATA);
  assign ctrl_wr  = wr_en & (sel == SEL_CTRL);
  assign pop      = rd_en & (sel == SEL_DATA);
  assign flush    = ctrl_wr & data_in[KBD_CTRL_FLUSH];
  assign ovf_clr  = ctrl_wr & data_in[KBD_CTRL_OVF_CLR];

  // Scan side wins a push collision; the dropped bus write counts as overflow
  assign push      = key_valid | bus_push;
  assign push_data = key_valid ? key_code : data_in;
  assign ovf_set   = (key_valid & bus_push) | (push & full & ~pop);

  kbd_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef KBD_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= data_in[KBD_CTRL_IRQ_EN];
      irq_q <= irq_en & ~empty;
    end
  end

  assign irq_pend = irq_en & ~empty;
  assign irq      = irq_q;
`else
  assign irq_en   = 1'b0;
  assign irq_pend = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    unique case (sel)
      SEL_DATA: if (!empty) rd_data = head;
      SEL_STATUS: begin
        rd_data[KBD_STAT_EMPTY] = empty;
        rd_data[KBD_STAT_FULL]  = full;
        rd_data[KBD_STAT_OVF]   = overflow;
        rd_data[KBD_STAT_IRQ]   = irq_pend;
      end
      SEL_CTRL:  rd_data[KBD_CTRL_IRQ_EN] = irq_en;
      SEL_COUNT: rd_data = DATA_W'(count);
      SEL_NONE:  rd_data = '0;
      default:   rd_data = '0;
    endcase
  end

  // Sampled from pre-edge state, so a same-cycle write is not visible here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     data_out <= '0;
    else if (rd_en) data_out <= rd_data;
  end

endmodule

// File: tb/tb_kbd_fifo_periph.sv
// Self-checking bench for kbd_fifo_periph: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_kbd_fifo_periph;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 8;
`ifdef KBD_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic          key_valid = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] key_code = '0;
  logic [DW-1:0] data_out;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] m_q[$];
  logic          m_ovf;
  logic          m_irq_en;
  logic          m_irq;
  logic [DW-1:0] m_dout;

  kbd_fifo_periph #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .address   (address),
    .data_in   (data_in),
    .data_out  (data_out),
    .write     (write),
    .read      (read),
    .key_valid (key_valid),
    .key_code  (key_code),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_q.delete();
    m_ovf    = 1'b0;
    m_irq_en = 1'b0;
    m_irq    = 1'b0;
    m_dout   = '0;
  endtask

  task automatic model_step(input logic kv, input logic [DW-1:0] kc, input logic en,
                            input logic rd, input logic wr, input logic [AW-1:0] ad,
                            input logic [DW-1:0] wd);
    int unsigned   n;
    logic          rd_en, wr_en, do_pop, push_req, coll, flush, oclr;
    logic [DW-1:0] rv, pv;
    n     = m_q.size();
    rd_en = en & rd;
    wr_en = en & wr;
    rv    = '0;
    case (ad)
      8'd0: if (n > 0) rv = m_q[0];
      8'd1: begin
        rv[0] = (n == 0);
        rv[1] = (n == DEPTH);
        rv[2] = m_ovf;
        rv[3] = HAS_IRQ && m_irq_en && (n > 0);
      end
      8'd2: rv[0] = m_irq_en;
      8'd3: rv = DW'(n);
      default: rv = '0;
    endcase
    m_irq = HAS_IRQ && m_irq_en && (n > 0);
    if (rd_en) m_dout = rv;
    flush    = wr_en && ad == 8'd2 && wd[1];
    oclr     = wr_en && ad == 8'd2 && wd[2];
    do_pop   = rd_en && ad == 8'd0 && n > 0;
    push_req = kv || (wr_en && ad == 8'd0);
    pv       = kv ? kc : wd;
    coll     = kv && wr_en && ad == 8'd0;
    if (coll || (push_req && n == DEPTH && !do_pop)) m_ovf = 1'b1;
    else if (oclr) m_ovf = 1'b0;
    if (flush) m_q.delete();
    else begin
      if (do_pop) void'(m_q.pop_front());
      if (push_req && (n < DEPTH || do_pop)) m_q.push_back(pv);
    end
    if (HAS_IRQ && wr_en && ad == 8'd2) m_irq_en = wd[0];
  endtask

  task automatic do_cycle(input logic kv, input logic [DW-1:0] kc, input logic en,
                          input logic rd, input logic wr, input logic [AW-1:0] ad,
                          input logic [DW-1:0] wd);
    @(negedge clk);
    key_valid = kv; key_code = kc; enable = en; read = rd; write = wr;
    address = ad; data_in = wd;
    model_step(kv, kc, en, rd, wr, ad, wd);
    @(posedge clk);
    #1;
    key_valid = 1'b0; enable = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic key_push(input logic [DW-1:0] c);
    do_cycle(1'b1, c, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic bus_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic bus_rd(input logic [AW-1:0] a);
    do_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, a, '0);
  endtask

  task automatic idle();
    do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", data_out); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    @(negedge clk);
    rst_n = 1'b1;
    bus_rd(8'd1);
    n_tests++;
    if (data_out !== 8'h01) begin n_fail++; $display("FAIL reset_status: got %h expected 01", data_out); end
    bus_rd(8'd3);
    n_tests++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h expected 00", data_out); end
  endtask

  task automatic test_fifo_order();
    logic [DW-1:0] codes [3] = '{8'h1C, 8'h32, 8'h21};
    for (int i = 0; i < 3; i++) key_push(codes[i]);
    for (int i = 0; i < 3; i++) begin
      bus_rd(8'd0);
      n_tests++;
      if (data_out !== codes[i]) begin
        n_fail++; $display("FAIL order_read%0d: got %h expected %h", i, data_out, codes[i]);
      end
    end
    bus_rd(8'd1);
    n_tests++;
    if (data_out !== 8'h01) begin n_fail++; $display("FAIL order_status: got %h expected 01", data_out); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) key_push(8'h40 + 8'(i));
    bus_rd(8'd1);
    n_tests++;
    if (data_out !== 8'h06) begin n_fail++; $display("FAIL ovf_status: got %h expected 06", data_out); end
    bus_rd(8'd3);
    n_tests++;
    if (data_out !== 8'd16) begin n_fail++; $display("FAIL ovf_count: got %h expected 10", data_out); end
    bus_wr(8'd2, 8'h04);
    bus_rd(8'd1);
    n_tests++;
    if (data_out !== 8'h02) begin n_fail++; $display("FAIL ovf_clear: got %h expected 02", data_out); end
    bus_wr(8'd2, 8'h02);
    bus_rd(8'd1);
    n_tests++;
    if (data_out !== 8'h01) begin n_fail++; $display("FAIL flush_status: got %h expected 01", data_out); end
    bus_rd(8'd3);
    n_tests++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL flush_count: got %h expected 00", data_out); end
  endtask

  task automatic test_collision();
    do_cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 8'd0, 8'h55);
    bus_rd(8'd3);
    n_tests++;
    if (data_out !== 8'h01) begin n_fail++; $display("FAIL coll_count: got %h expected 01", data_out); end
    bus_rd(8'd1);
    n_tests++;
    if (data_out !== 8'h04) begin n_fail++; $display("FAIL coll_status: got %h expected 04", data_out); end
    bus_rd(8'd0);
    n_tests++;
    if (data_out !== 8'hAA) begin n_fail++; $display("FAIL coll_data: got %h expected aa", data_out); end
    bus_wr(8'd2, 8'h04);
    bus_rd(8'd1);
    n_tests++;
    if (data_out !== 8'h01) begin n_fail++; $display("FAIL coll_after: got %h expected 01", data_out); end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 16; i++) key_push(8'h80 + 8'(i));
    do_cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 8'd0, '0);
    n_tests++;
    if (data_out !== 8'h80) begin n_fail++; $display("FAIL pp_head: got %h expected 80", data_out); end
    bus_rd(8'd3);
    n_tests++;
    if (data_out !== 8'd16) begin n_fail++; $display("FAIL pp_count: got %h expected 10", data_out); end
    bus_rd(8'd1);
    n_tests++;
    if (data_out !== 8'h02) begin n_fail++; $display("FAIL pp_status: got %h expected 02", data_out); end
    for (int i = 1; i < 16; i++) begin
      bus_rd(8'd0);
      n_tests++;
      if (data_out !== 8'h80 + 8'(i)) begin
        n_fail++; $display("FAIL pp_drain%0d: got %h expected %h", i, data_out, 8'h80 + 8'(i));
      end
    end
    bus_rd(8'd0);
    n_tests++;
    if (data_out !== 8'h77) begin n_fail++; $display("FAIL pp_last: got %h expected 77", data_out); end
  endtask

  task automatic test_irq();
`ifdef KBD_IRQ_EN
    bus_wr(8'd2, 8'h01);
    bus_rd(8'd2);
    n_tests++;
    if (data_out !== 8'h01) begin n_fail++; $display("FAIL irq_ctrl: got %h expected 01", data_out); end
    key_push(8'h5A);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b expected 0", irq); end
    idle();
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_assert: got %b expected 1", irq); end
    bus_rd(8'd1);
    n_tests++;
    if (data_out !== 8'h08) begin n_fail++; $display("FAIL irq_status: got %h expected 08", data_out); end
    bus_rd(8'd0);
    n_tests++;
    if (data_out !== 8'h5A) begin n_fail++; $display("FAIL irq_pop: got %h expected 5a", data_out); end
    idle();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_deassert: got %b expected 0", irq); end
`else
    bus_wr(8'd2, 8'h01);
    bus_rd(8'd2);
    n_tests++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL irq_ctrl: got %h expected 00", data_out); end
    key_push(8'h5A);
    idle();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_tied: got %b expected 0", irq); end
    bus_rd(8'd1);
    n_tests++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL irq_status: got %h expected 00", data_out); end
    bus_rd(8'd0);
    n_tests++;
    if (data_out !== 8'h5A) begin n_fail++; $display("FAIL irq_pop: got %h expected 5a", data_out); end
`endif
  endtask

  task automatic test_reset_midop();
    bus_wr(8'd2, 8'h01);
    key_push(8'h11);
    key_push(8'h22);
    idle();
    @(negedge clk);
    enable = 1'b1; read = 1'b1; address = 8'd0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_dout: got %h expected 00", data_out); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b expected 0", irq); end
    @(posedge clk);
    #1;
    n_tests++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_inflight: got %h expected 00", data_out); end
    enable = 1'b0; read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bus_rd(8'd3);
    n_tests++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_count: got %h expected 00", data_out); end
    bus_rd(8'd2);
    n_tests++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_ctrl: got %h expected 00", data_out); end
  endtask

  task automatic test_random();
    logic          kv, en, rd, wr;
    logic [DW-1:0] kc, wd;
    logic [AW-1:0] ad;
    int unsigned   r;
    for (int i = 0; i < 800; i++) begin
      kv = ($urandom_range(0, 99) < 35);
      kc = DW'($urandom);
      en = ($urandom_range(0, 99) < 60);
      rd = DW'($urandom) < 8'd128;
      wr = DW'($urandom) < 8'd110;
      r  = $urandom_range(0, 9);
      if (r < 8)       ad = AW'(r % 4);
      else if (r == 8) ad = 8'd4;
      else             ad = AW'($urandom_range(5, 255));
      wd = DW'($urandom);
      if (ad == 8'd2) wd[1] = ($urandom_range(0, 15) == 0);
      do_cycle(kv, kc, en, rd, wr, ad, wd);
      n_tests++;
      if (data_out !== m_dout) begin
        n_fail++; $display("FAIL rand_dout[%0d]: got %h expected %h", i, data_out, m_dout);
      end
      n_tests++;
      if (irq !== m_irq) begin
        n_fail++; $display("FAIL rand_irq[%0d]: got %b expected %b", i, irq, m_irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow();
    test_collision();
    test_full_pushpop();
    test_irq();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
